// File: rtl/inst_fetch.sv
// Instruction sequencer: host-loaded program memory stepped by a PC on start.
// Define INST_FETCH_PREFETCH_EN for back-to-back (1 word/cycle) issue.
module inst_fetch #(
  parameter int op_size = 4,
  parameter int param_a = 4,
  parameter int param_b = 4,
  parameter int depth   = 16,
  parameter int addr_w  = 4,
  parameter logic [op_size-1:0] halt_op = {op_size{1'b1}},
  localparam int code_size = op_size + param_a + param_b
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [addr_w-1:0]    load_addr,
  input  logic [code_size-1:0] load_data,
  input  logic                 start,
  input  logic                 abort,
  output logic [code_size-1:0] code,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic [addr_w-1:0]    pc,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    DONE
  } state_e;

  localparam logic [addr_w-1:0] last_pc = addr_w'(depth - 1);

  state_e               state_q, state_d;
  logic [code_size-1:0] code_q, code_d;
  logic [addr_w-1:0]    pc_q, pc_d;
  logic [code_size-1:0] mem_q [depth];

  logic mem_we;
  logic is_halt;
  logic at_end;

  assign mem_we  = (state_q == IDLE) && load_en;
  assign is_halt = code_q[code_size-1 -: op_size] == halt_op;
  assign at_end  = pc_q == last_pc;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pc_d       = pc_q;
    code_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        code_d  = mem_q[pc_q];
        state_d = VALID;
      end
      VALID: begin
        code_valid = !is_halt;
        if (is_halt) begin
          state_d = DONE;
        end else if (code_ready) begin
          if (at_end) begin
            state_d = DONE;
          end else begin
            pc_d = pc_q + addr_w'(1);
`ifdef INST_FETCH_PREFETCH_EN
            code_d = mem_q[pc_d];
`else
            state_d = FETCH;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // abort wins over handshake and halt; no word is handed over
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      code_d     = code_q;
      pc_d       = pc_q;
      code_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign code = code_q;
  assign pc   = pc_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch.
// Build with INST_FETCH_PREFETCH_EN to check the prefetch timing.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_data;
  logic        start;
  logic        abort;
  logic [11:0] code;
  logic        code_valid;
  logic        code_ready;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .abort      (abort),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  int checks   = 0;
  int failures = 0;

  logic [11:0] got_code [$];
  int          got_pc   [$];
  int          got_cyc  [$];
  int          done_cnt;

`ifdef INST_FETCH_PREFETCH_EN
  localparam int third_cyc = 3;
`else
  localparam int third_cyc = 5;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [11:0] d);
    load_en   = 1'b1;
    load_addr = a[3:0];
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic load_prog;
    load_word(0, 12'h123);
    load_word(1, 12'h456);
    load_word(2, 12'h789);
    load_word(3, 12'hF00);
  endtask

  task automatic go;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // collect handshakes until done (or idle), sampling after each edge
  task automatic run(input int max_cyc);
    bit timed_out;
    got_code.delete();
    got_pc.delete();
    got_cyc.delete();
    done_cnt  = 0;
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (code_valid && code_ready) begin
        got_code.push_back(code);
        got_pc.push_back(int'(pc));
        got_cyc.push_back(i);
      end
      if (done) begin
        done_cnt++;
        timed_out = 1'b0;
        tick();
        break;
      end
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    check_eq("run_timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic wait_pc1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (code_valid && pc == 4'd1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit          ok;
    bit          stable;
    int          bad;
    int          seen_done;
    logic [11:0] fill [16];

    reset      = 1'b1;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    start      = 1'b0;
    abort      = 1'b0;
    code_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_code", 32'(code), 32'h0);
    check_eq("rst_valid", 32'(code_valid), 32'h0);
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);

    // basic program ending in halt
    load_prog();
    code_ready = 1'b1;
    go();
    run(40);
    check_eq("t1_count", 32'(got_code.size()), 32'd3);
    check_eq("t1_code0", 32'(got_code[0]), 32'h123);
    check_eq("t1_code1", 32'(got_code[1]), 32'h456);
    check_eq("t1_code2", 32'(got_code[2]), 32'h789);
    check_eq("t1_pc2", 32'(got_pc[2]), 32'd2);
    check_eq("t1_lat", 32'(got_cyc[0]), 32'd1);
    check_eq("t1_cyc2", 32'(got_cyc[2]), 32'(third_cyc));
    check_eq("t1_done", 32'(done_cnt), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_pc_end", 32'(pc), 32'd3);

    // back-pressure on word 1
    go();
    wait_pc1(ok);
    check_eq("t2_reach", 32'(ok), 32'd1);
    code_ready = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(code_valid && code == 12'h456 && pc == 4'd1)) stable = 1'b0;
      tick();
    end
    check_eq("t2_stable", 32'(stable), 32'd1);
    code_ready = 1'b1;
    run(40);
    check_eq("t2_count", 32'(got_code.size()), 32'd2);
    check_eq("t2_code0", 32'(got_code[0]), 32'h456);
    check_eq("t2_code1", 32'(got_code[1]), 32'h789);
    check_eq("t2_done", 32'(done_cnt), 32'd1);

    // full memory, no halt
    for (int i = 0; i < 16; i++) begin
      fill[i] = {4'(i % 15), 8'(i * 17)};
      load_word(i, fill[i]);
    end
    go();
    run(80);
    check_eq("t3_count", 32'(got_code.size()), 32'd16);
    bad = 0;
    for (int i = 0; i < got_code.size(); i++) begin
      if (got_code[i] !== fill[i] || got_pc[i] != i) bad++;
    end
    check_eq("t3_words", 32'(bad), 32'd0);
    check_eq("t3_done", 32'(done_cnt), 32'd1);
    check_eq("t3_pc_end", 32'(pc), 32'd15);

    // abort while word 1 pending, then replay
    load_prog();
    go();
    wait_pc1(ok);
    check_eq("t4_reach", 32'(ok), 32'd1);
    code_ready = 1'b0;
    abort      = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t4_valid", 32'(code_valid), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) seen_done++;
      tick();
    end
    check_eq("t4_no_done", 32'(seen_done), 32'd0);
    code_ready = 1'b1;
    go();
    run(40);
    check_eq("t4_count", 32'(got_code.size()), 32'd3);
    check_eq("t4_first", 32'(got_code[0]), 32'h123);
    check_eq("t4_first_pc", 32'(got_pc[0]), 32'd0);
    check_eq("t4_done", 32'(done_cnt), 32'd1);

    // loads while busy are ignored
    code_ready = 1'b0;
    go();
    load_en   = 1'b1;
    load_addr = 4'd2;
    load_data = 12'hAAA;
    tick();
    tick();
    load_en    = 1'b0;
    code_ready = 1'b1;
    run(40);
    check_eq("t5_count", 32'(got_code.size()), 32'd3);
    check_eq("t5_word2", 32'(got_code[2]), 32'h789);

    // reset mid-run
    go();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_eq("t6_outs", 32'({code, code_valid, pc, busy, done}), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("t6_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
